// File: rtl/descrambler_sync.sv
// Receive-side x^7+x^4+1 descrambler: rebuilds the scrambler state from the seven
// SERVICE bits of each frame, then descrambles the remaining bits one per valid cycle.
module descrambler_sync #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sof,
    input  logic             in_valid,
    input  logic             x_in,
    input  logic [LEN_W-1:0] num_bits,
    output logic             x_descrambled,
    output logic             out_valid,
    output logic [6:0]       seed_out,
    output logic             seed_valid,
    output logic             seed_err,
    output logic             frame_done
);

    typedef enum logic [1:0] {IDLE, SEED, DESC} state_t;

    state_t           state, state_n;
    logic [6:0]       lfsr, lfsr_n;
    logic [LEN_W-1:0] count, count_n;
    logic [LEN_W-1:0] len, len_n;
    logic             xd_n, ov_n, sv_n, err_n, fd_n;
    logic [6:0]       seed_n;
    logic [6:0]       shifted;
    logic             fb;

    // r holds {s1..s7}; unwinds seven scrambler steps back to the initial state
    function automatic logic [6:0] back_seed(input logic [6:0] r);
        logic [6:0] a;
        a[0] = r[0] ^ r[4];
        a[1] = r[1] ^ r[5];
        a[2] = r[2] ^ r[6];
        a[3] = r[3] ^ a[0];
        a[4] = r[4] ^ a[1];
        a[5] = r[5] ^ a[2];
        a[6] = r[6] ^ a[3];
        return a;
    endfunction

    assign shifted = {lfsr[5:0], x_in};
    assign fb      = lfsr[6] ^ lfsr[3];

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        count_n = count;
        len_n   = len;
        xd_n    = x_descrambled;
        ov_n    = 1'b0;
        sv_n    = 1'b0;
        seed_n  = seed_out;
        err_n   = seed_err;
        fd_n    = 1'b0;
        if (in_valid) begin
            if (sof) begin
                // a start of frame always wins, even in the middle of another frame
                len_n   = (num_bits == '0) ? LEN_W'(1) : num_bits;
                lfsr_n  = shifted;
                count_n = LEN_W'(1);
                err_n   = 1'b0;
                xd_n    = 1'b0;
                ov_n    = 1'b1;
                state_n = SEED;
                if (len_n == LEN_W'(1)) begin
                    fd_n    = 1'b1;
                    state_n = IDLE;
                end
            end else begin
                case (state)
                    SEED: begin
                        lfsr_n  = shifted;
                        count_n = count + LEN_W'(1);
                        xd_n    = 1'b0;
                        ov_n    = 1'b1;
                        if (count_n == LEN_W'(7)) begin
                            sv_n    = 1'b1;
                            seed_n  = back_seed(shifted);
                            err_n   = (seed_n == 7'h00);
                            state_n = DESC;
                        end
                        if (count_n == len) begin
                            fd_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                    DESC: begin
                        lfsr_n  = {lfsr[5:0], fb};
                        count_n = count + LEN_W'(1);
                        xd_n    = x_in ^ fb;
                        ov_n    = 1'b1;
                        if (count_n == len) begin
                            fd_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= 7'h00;
            count         <= '0;
            len           <= '0;
            x_descrambled <= 1'b0;
            out_valid     <= 1'b0;
            seed_out      <= 7'h00;
            seed_valid    <= 1'b0;
            seed_err      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_n;
            lfsr          <= lfsr_n;
            count         <= count_n;
            len           <= len_n;
            x_descrambled <= xd_n;
            out_valid     <= ov_n;
            seed_out      <= seed_n;
            seed_valid    <= sv_n;
            seed_err      <= err_n;
            frame_done    <= fd_n;
        end
    end

endmodule

// File: tb/tb_descrambler_sync.sv
// Bench for descrambler_sync: frames are produced by a transmit-scrambler model from
// known data and seeds, and every output is compared against that original data.
module tb_descrambler_sync;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             sof;
    logic             in_valid;
    logic             x_in;
    logic [LEN_W-1:0] num_bits;
    logic             x_descrambled;
    logic             out_valid;
    logic [6:0]       seed_out;
    logic             seed_valid;
    logic             seed_err;
    logic             frame_done;

    descrambler_sync #(.LEN_W(LEN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sof           (sof),
        .in_valid      (in_valid),
        .x_in          (x_in),
        .num_bits      (num_bits),
        .x_descrambled (x_descrambled),
        .out_valid     (out_valid),
        .seed_out      (seed_out),
        .seed_valid    (seed_valid),
        .seed_err      (seed_err),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       xd;
        logic       sv;
        logic [6:0] seed;
        logic       err;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [6:0] seed;
        int         nb;
        int         sent;
        int         rand_data;
        logic [6:0] exp_seed;
        logic       exp_err;
        int         exp_outs;
        int         exp_sv;
        int         exp_fd;
    } vec_t;

    exp_t       expq[$];
    logic       data_buf [0:511];
    int         checks = 0;
    int         failures = 0;
    int         ov_count = 0;
    int         sv_count = 0;
    int         fd_count = 0;

    // reference model of the frame currently being received
    bit         m_active = 1'b0;
    int         m_idx = 0;
    int         m_len = 0;
    logic [6:0] m_frame_seed = 7'h00;
    logic [6:0] m_seed_out = 7'h00;
    logic       m_err = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [LEN_W-1:0] nb, input logic dbit);
        exp_t e;
        if (s) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_len    = (nb == '0) ? 1 : int'(nb);
            m_err    = 1'b0;
        end
        if (m_active) begin
            m_idx++;
            if (m_idx == 7) begin
                m_seed_out = m_frame_seed;
                m_err      = (m_frame_seed == 7'h00);
            end
            e.xd   = dbit;
            e.sv   = (m_idx == 7);
            e.seed = m_seed_out;
            e.err  = m_err;
            e.fd   = (m_idx == m_len);
            if (e.fd) m_active = 1'b0;
            expq.push_back(e);
        end
        sof      = s;
        in_valid = 1'b1;
        x_in     = b;
        num_bits = nb;
        @(posedge clk);
        #1;
        sof      = 1'b0;
        in_valid = 1'b0;
        x_in     = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            sof      = 1'($urandom);
            x_in     = 1'($urandom);
            @(posedge clk);
            #1;
        end
        sof  = 1'b0;
        x_in = 1'b0;
    endtask

    task automatic fillData(input int rand_data);
        for (int k = 0; k < 512; k++)
            data_buf[k] = (k < 7 || rand_data == 0) ? 1'b0 : 1'($urandom);
    endtask

    // transmit scrambler: tap = s[6]^s[3], shift left, tap fed back into s[0]
    task automatic sendFrame(input logic [6:0] seed, input int nb, input int sent, input int gap_pct);
        logic [6:0] st;
        logic       tap;
        st = seed;
        m_frame_seed = seed;
        for (int k = 0; k < sent; k++) begin
            tap = st[6] ^ st[3];
            st  = {st[5:0], tap};
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idleCycles(1);
            applyStimulus(k == 0, data_buf[k] ^ tap, LEN_W'(nb), data_buf[k]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            ov_count++;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_out_valid: got 1, expected 0 at %0t", $time);
            end else begin
                e = expq.pop_front();
                checkOutput("x_descrambled", 32'(x_descrambled), 32'(e.xd));
                checkOutput("seed_valid", 32'(seed_valid), 32'(e.sv));
                checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
                checkOutput("seed_out", 32'(seed_out), 32'(e.seed));
                checkOutput("seed_err", 32'(seed_err), 32'(e.err));
            end
        end else if (seed_valid === 1'b1 || frame_done === 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray_pulse: got sv=%0b fd=%0b, expected 0 without out_valid", seed_valid, frame_done);
        end
        if (seed_valid === 1'b1) sv_count++;
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   ov0, sv0, fd0;
        logic [6:0] rseed;
        int   rnb, rsent;

        vecs[0] = '{7'h7F, 40, 40, 0, 7'h7F, 1'b0, 40, 1, 1};
        vecs[1] = '{7'h00, 30, 30, 1, 7'h00, 1'b1, 30, 1, 1};
        vecs[2] = '{7'h7F, 5, 5, 0, 7'h00, 1'b0, 5, 0, 1};
        vecs[3] = '{7'h12, 0, 1, 1, 7'h00, 1'b0, 1, 0, 1};
        vecs[4] = '{7'h33, 7, 7, 1, 7'h33, 1'b0, 7, 1, 1};
        vecs[5] = '{7'h5D, 100, 50, 1, 7'h5D, 1'b0, 50, 1, 0};
        vecs[6] = '{7'h2A, 60, 60, 1, 7'h2A, 1'b0, 60, 1, 1};

        sof = 1'b0; in_valid = 1'b0; x_in = 1'b0; num_bits = '0; reset = 1'b0;
        #1 reset = 1'b1;
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_x_descrambled", 32'(x_descrambled), 32'd0);
        checkOutput("reset_seed_out", 32'(seed_out), 32'd0);
        checkOutput("reset_seed_valid", 32'(seed_valid), 32'd0);
        checkOutput("reset_seed_err", 32'(seed_err), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            ov0 = ov_count; sv0 = sv_count; fd0 = fd_count;
            fillData(vecs[v].rand_data);
            sendFrame(vecs[v].seed, vecs[v].nb, vecs[v].sent, 0);
            idleCycles(3);
            checkOutput($sformatf("vec%0d_outputs", v), 32'(ov_count - ov0), 32'(vecs[v].exp_outs));
            checkOutput($sformatf("vec%0d_seed_valids", v), 32'(sv_count - sv0), 32'(vecs[v].exp_sv));
            checkOutput($sformatf("vec%0d_frame_dones", v), 32'(fd_count - fd0), 32'(vecs[v].exp_fd));
            checkOutput($sformatf("vec%0d_seed_out", v), 32'(seed_out), 32'(vecs[v].exp_seed));
            checkOutput($sformatf("vec%0d_seed_err", v), 32'(seed_err), 32'(vecs[v].exp_err));
        end

        fillData(1);
        for (int pass = 0; pass < 2; pass++) begin
            ov0 = ov_count; fd0 = fd_count;
            sendFrame(7'h5D, 200, 200, (pass == 0) ? 0 : 40);
            idleCycles(3);
            checkOutput($sformatf("rand200_pass%0d_outputs", pass), 32'(ov_count - ov0), 32'd200);
            checkOutput($sformatf("rand200_pass%0d_frame_done", pass), 32'(fd_count - fd0), 32'd1);
            checkOutput($sformatf("rand200_pass%0d_seed_out", pass), 32'(seed_out), 32'h5D);
        end

        ov0 = ov_count;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'($urandom), LEN_W'(20), 1'b0);
        idleCycles(2);
        checkOutput("idle_bits_dropped", 32'(ov_count - ov0), 32'd0);

        for (int r = 0; r < 6; r++) begin
            rseed = 7'($urandom);
            rnb   = $urandom_range(150, 1);
            rsent = (r % 3 == 2) ? $urandom_range(rnb, 1) : rnb;
            fillData(1);
            sendFrame(rseed, rnb, rsent, 20);
            idleCycles($urandom_range(4, 0));
        end

        fillData(1);
        sendFrame(7'h44, 80, 20, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_x_descrambled", 32'(x_descrambled), 32'd0);
        checkOutput("midreset_seed_out", 32'(seed_out), 32'd0);
        checkOutput("midreset_seed_valid", 32'(seed_valid), 32'd0);
        checkOutput("midreset_seed_err", 32'(seed_err), 32'd0);
        checkOutput("midreset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("midreset_pending", 32'(expq.size()), 32'd0);
        m_active = 1'b0; m_seed_out = 7'h00; m_err = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        ov0 = ov_count;
        idleCycles(3);
        checkOutput("post_reset_silent", 32'(ov_count - ov0), 32'd0);

        ov0 = ov_count; fd0 = fd_count;
        fillData(1);
        sendFrame(7'h6B, 50, 50, 10);
        idleCycles(3);
        checkOutput("post_reset_outputs", 32'(ov_count - ov0), 32'd50);
        checkOutput("post_reset_frame_done", 32'(fd_count - fd0), 32'd1);
        checkOutput("post_reset_seed_out", 32'(seed_out), 32'h6B);
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/descrambler_sync.md
Name: descrambler_sync

Overview:
- Receive-side counterpart of the transmit scrambler (x^7 + x^4 + 1, 7-bit LFSR, tap = state[6]^state[3], shift left, feedback into state[0]).
- Recovers the scrambler state from the first 7 SERVICE bits of each frame; these bits are transmitted as zeros, so the received bits are the raw sequence.
- Descrambles the rest of the DATA field serially, reports the recovered initial seed, and flags an all-zero seed.
- Sits after the Viterbi decoder and before SERVICE/PSDU extraction.

Parameters:
LEN_W, 16, width of the frame bit-count input (max frame = 2^LEN_W-1 bits)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sof  input  1  start of frame; qualified by in_valid, marks the first SERVICE bit
in_valid  input  1  x_in carries a valid scrambled bit this cycle
x_in  input  1  scrambled serial bit
num_bits  input  LEN_W  total bits in the frame, SERVICE included; sampled when sof & in_valid
x_descrambled  output  1  descrambled bit
out_valid  output  1  x_descrambled valid (one-cycle pulse per bit)
seed_out  output  7  recovered initial scrambler state; seed_out[6] is the x^7 stage
seed_valid  output  1  one-cycle pulse when seed_out updates
seed_err  output  1  recovered seed is 7'h00; held until the next sof
frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR 7'h00, counters 0.
- FSM states: IDLE, SEED, DESC. Only cycles with in_valid=1 advance. Gaps of any length are allowed; outputs hold, with out_valid=0.
- IDLE -> SEED on sof&in_valid:
  - latch num_bits;
  - shift x_in into LFSR[0];
  - set bit count to 1;
  - clear seed_err.
  - sof without in_valid is ignored.
- SEED:
  - each valid bit shifts into LFSR (LFSR <= {LFSR[5:0], x_in}).
  - x_descrambled = x_in ^ x_in = 0 for all 7 bits.
  - After bit 7, LFSR = {s1..s7}, the live scrambler state. Go to DESC.
- Seed back-computation, with s1 the first received bit:
  - a0=s7^s3, a1=s6^s2, a2=s5^s1, a3=s4^a0, a4=s3^a1, a5=s2^a2, a6=s1^a3.
  - seed_out={a6..a0} and seed_valid pulse in the cycle out_valid fires for bit 7.
  - seed_err=1 in that same cycle if seed_out==0.
- DESC, per valid bit:
  - p = LFSR[6]^LFSR[3];
  - x_descrambled <= x_in ^ p;
  - LFSR <= {LFSR[5:0], p}.
- Latency: registered; out_valid/x_descrambled appear the cycle after the in_valid input cycle, one output per input bit, order preserved.
- Termination: when the bit count reaches the latched num_bits, frame_done pulses with that bit's output and the FSM returns to IDLE.
- num_bits edge cases:
  - num_bits < 7: the frame ends inside SEED after num_bits outputs; seed_valid is not asserted.
  - num_bits = 0: treated as 1.
- Abort/restart: sof&in_valid in SEED or DESC aborts the current frame without frame_done and restarts at SEED with that bit as s1.
- Idle inputs: in_valid bits in IDLE without sof are dropped, producing no output.
- Async reset mid-frame returns to IDLE immediately. No output pulses are produced until the next sof.
- The bit count is LEN_W wide and never wraps, because the frame ends at num_bits.

Test Plan:
- Seed all-ones:
  - frame 40 bits, scrambled from all-zero data, so received bits = 0000111 0111 1001 0110 0100 1000 0001 0001 0011 0 ...
  - Required: seed_out=7'h7F and seed_valid on the 7th output; all 40 x_descrambled=0; frame_done on the 40th.
- Random data, seed 7'h5D:
  - drive the 200-bit output of the transmit scrambler (MODE=1).
  - Required: x_descrambled matches the original data bitwise; seed_out=7'h5D.
- in_valid gaps:
  - same stimulus as above with in_valid randomly 0 about 40% of cycles.
  - Required: identical output bit stream; out_valid count = 200.
- Zero seed:
  - first 7 received bits 0000000.
  - Required: seed_out=0 and seed_err=1 until the next sof; output equals input thereafter (p=0).
- Restart and short frame:
  - sof at bit 50 of a 100-bit frame.
  - Required: no frame_done for the first frame; the new frame's seed is recovered correctly.
  - num_bits=5: 5 zero outputs, frame_done on the 5th, no seed_valid.
- Async reset:
  - assert reset at bit 20 of a frame.
  - Required: all outputs 0 within the same cycle; the subsequent frame decodes correctly.
